// File: rtl/msk_loop_ctrl.sv
// Round iteration controller with a masked state register fed by a share-wise 2:1 MUX.
// Optional build macro MSK_LOOP_CLEAR_EN: wipe the state register on the DONE->IDLE edge.
module msk_loop_ctrl #(
  parameter int d      = 1,
  parameter int count  = 1,
  parameter int ROUNDS = 4,
  parameter int LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [count*d-1:0]            in_sharing,
  input  logic [count*d-1:0]            fb_sharing,
  output logic [count*d-1:0]            state_sharing,
  output logic                          mux_sel,
  output logic [$clog2(ROUNDS+1)-1:0]   round,
  output logic                          busy,
  output logic                          out_valid
);

  localparam int SW = count * d;
  localparam int RW = $clog2(ROUNDS + 1);
  localparam int WW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [WW-1:0] LAST_WAIT  = WW'(LAT - 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   round_q, round_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [SW-1:0]   sreg_q, sreg_d;
  logic            busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic            mux_sel_q, mux_sel_d;
  logic            load_en_s;
  logic            clr_s;
  logic [SW-1:0]   mux_s;

  // Bitwise select keeps every share on its own wire; the select never sees sharing data.
  assign mux_s = mux_sel_q ? in_sharing : fb_sharing;

  // Next-state, counter and register-update logic.
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    wait_d    = wait_q;
    load_en_s = 1'b0;
    clr_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_en_s = 1'b1;
          round_d   = '0;
          wait_d    = '0;
          state_d   = RUN;
        end else begin
          state_d   = IDLE;
        end
      end
      RUN: begin
        if (wait_q == LAST_WAIT) begin
          load_en_s = 1'b1;
          wait_d    = '0;
          round_d   = round_q + RW'(1);
          if (round_q == LAST_ROUND) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          wait_d    = wait_q + WW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        round_d = '0;
`ifdef MSK_LOOP_CLEAR_EN
        clr_s   = 1'b1;
`else
        clr_s   = 1'b0;
`endif
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
        wait_d  = '0;
      end
    endcase

    if (load_en_s) begin
      sreg_d = mux_s;
    end else if (clr_s) begin
      sreg_d = '0;
    end else begin
      sreg_d = sreg_q;
    end

    // Control outputs are registered images of the next state so they change with it.
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
    mux_sel_d   = (state_d == IDLE);
  end

  // State, counter, masked register and control output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      round_q     <= '0;
      wait_q      <= '0;
      sreg_q      <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      mux_sel_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      wait_q      <= wait_d;
      sreg_q      <= sreg_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      mux_sel_q   <= mux_sel_d;
    end
  end

  assign state_sharing = sreg_q;
  assign round         = round_q;
  assign busy          = busy_q;
  assign out_valid     = out_valid_q;
  assign mux_sel       = mux_sel_q;

endmodule

// File: tb/tb_msk_loop_ctrl.sv
// Directed bench for msk_loop_ctrl with d=2, count=1, ROUNDS=3, LAT=2.
module tb_msk_loop_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] in_sharing;
  logic [1:0] fb_sharing;
  logic [1:0] state_sharing;
  logic       mux_sel;
  logic [1:0] round;
  logic       busy;
  logic       out_valid;

  int checks;
  int errors;

`ifdef MSK_LOOP_CLEAR_EN
  localparam logic [1:0] AFTER_RUN = 2'b00;
`else
  localparam logic [1:0] AFTER_RUN = 2'b01;
`endif

  msk_loop_ctrl #(.d(2), .count(1), .ROUNDS(3), .LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_sharing(in_sharing), .fb_sharing(fb_sharing),
    .state_sharing(state_sharing), .mux_sel(mux_sel), .round(round),
    .busy(busy), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expects start=1/in_sharing=din already driven in an IDLE cycle; walks the 7 run cycles.
  task automatic run_body(input logic [1:0] din, input bit poke);
    logic [1:0] exp_s;
    logic [1:0] exp_r;
    exp_s = din;
    @(negedge clk);
    in_sharing = ~din;
    for (int c = 1; c <= 7; c++) begin
      exp_r = 2'((c - 1) / 2);
      checks++; if (state_sharing !== exp_s) begin errors++; $display("FAIL run_state c=%0d got %b want %b", c, state_sharing, exp_s); end
      checks++; if (round !== exp_r) begin errors++; $display("FAIL run_round c=%0d got %0d want %0d", c, round, exp_r); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy c=%0d got %b want 1", c, busy); end
      checks++; if (mux_sel !== 1'b0) begin errors++; $display("FAIL run_mux_sel c=%0d got %b want 0", c, mux_sel); end
      checks++; if (out_valid !== (c == 7)) begin errors++; $display("FAIL run_out_valid c=%0d got %b want %b", c, out_valid, (c == 7)); end
      if (c % 2 == 0) begin
        fb_sharing = ~exp_s;
        exp_s      = ~exp_s;
      end else begin
        fb_sharing = (c % 4 == 1) ? 2'b11 : 2'b00;
      end
      start = poke && (c == 3 || c == 7);
      if (c < 7) @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag, input logic [1:0] exp_s);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy got %b want 0", tag, busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_out_valid got %b want 0", tag, out_valid); end
    checks++; if (mux_sel !== 1'b1) begin errors++; $display("FAIL %s_mux_sel got %b want 1", tag, mux_sel); end
    checks++; if (round !== 2'd0) begin errors++; $display("FAIL %s_round got %0d want 0", tag, round); end
    checks++; if (state_sharing !== exp_s) begin errors++; $display("FAIL %s_state got %b want %b", tag, state_sharing, exp_s); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_sharing = 2'b11; fb_sharing = 2'b11;
    #3;
    check_idle("reset_async", 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_released", 2'b00);
  endtask

  task automatic test_basic_run();
    start = 1'b1; in_sharing = 2'b10;
    run_body(2'b10, 1'b1);
    start = 1'b0;
    @(negedge clk);
    check_idle("after_done", AFTER_RUN);
    @(negedge clk);
    check_idle("no_requeue", AFTER_RUN);
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      fb_sharing = (i % 2 == 0) ? 2'b10 : 2'b11;
      in_sharing = (i % 2 == 0) ? 2'b11 : 2'b10;
      @(negedge clk);
    end
    check_idle("hold_10", AFTER_RUN);
  endtask

  task automatic test_back_to_back();
    start = 1'b1; in_sharing = 2'b10;
    run_body(2'b10, 1'b0);
    @(negedge clk);
    check_idle("b2b_gap", AFTER_RUN);
    start = 1'b1; in_sharing = 2'b11;
    run_body(2'b11, 1'b0);
    start = 1'b0;
    @(negedge clk);
    check_idle("b2b_end", 2'b00);
  endtask

  task automatic test_mid_run_reset();
    start = 1'b1; in_sharing = 2'b10;
    @(negedge clk);
    start = 1'b0; fb_sharing = 2'b00;
    @(negedge clk);
    fb_sharing = 2'b01;
    @(negedge clk);
    checks++; if (round !== 2'd1) begin errors++; $display("FAIL mid_pre_round got %0d want 1", round); end
    checks++; if (state_sharing !== 2'b01) begin errors++; $display("FAIL mid_pre_state got %b want 01", state_sharing); end
    #2 rst = 1'b1;
    #1;
    check_idle("mid_reset", 2'b00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_after i=%0d got ov=%b busy=%b want 0 0", i, out_valid, busy); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_run();
    test_hold();
    test_back_to_back();
    test_mid_run_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msk_loop_ctrl.md
Name: msk_loop_ctrl

Overview:
- Iteration controller and masked state register for round-based masked datapaths.
- Holds a `count`-sharing (d shares each) state register and drives the non-sensitive select of an internal masked 2-input MUX.
  - MUX true input: fresh input sharing.
  - MUX false input: feedback from the external round function.
- Sits directly upstream of the round-function gadgets and consumes their output.
- Sequences start, ROUNDS iterations of LAT cycles each, and completion.

Parameters:
- d, 1, number of shares per sharing (masking order + 1).
- count, 1, number of sharings carried in parallel.
- ROUNDS, 4, number of round-function iterations per run; must be ≥ 1.
- LAT, 1, latency in cycles of the external round function; must be ≥ 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  control; request a new run; sampled only in IDLE.
- in_sharing  input  count*d  sharing; fresh input, loaded at start.
- fb_sharing  input  count*d  sharing; round-function output, loaded at the end of each round.
- state_sharing  output  count*d  sharing; state register value, feeds the round function.
- mux_sel  output  1  control; 1 = select in_sharing, 0 = select fb_sharing.
- round  output  $clog2(ROUNDS+1)  control; index of the current round, 0..ROUNDS.
- busy  output  1  control; high from the cycle after start until out_valid is dropped.
- out_valid  output  1  control; single-cycle pulse; state_sharing holds the final result.

Behaviour:
- Reset (asynchronous, immediate):
  - FSM goes to IDLE.
  - state register cleared to all zeros.
  - round = 0, wait counter = 0.
  - busy = 0, out_valid = 0, mux_sel = 1.
- Reset asserted mid-run aborts the run. No partial out_valid is produced.
- State register:
  - Loads the MUX output only when load_en is high; otherwise it holds.
  - No other path writes it. Shares are never combined; bit i of the bus maps straight to bit i of the register.
- mux_sel and all other controls are derived only from FSM state and counters, never from sharing values.
- FSM states:
  - IDLE:
    - mux_sel = 1, busy = 0.
    - If start = 1: load_en = 1 (register ← in_sharing), round ← 0, wait ← 0, go to RUN.
  - RUN:
    - mux_sel = 0, busy = 1.
    - While wait < LAT-1: wait increments, no load.
    - When wait == LAT-1: load_en = 1 (register ← fb_sharing), wait ← 0, round increments.
    - If the round just completed was round ROUNDS-1, go to DONE.
  - DONE:
    - busy = 1, out_valid = 1, mux_sel = 0, no load. round reads ROUNDS.
    - Next edge: go to IDLE, round ← 0.
- Latency:
  - start sampled at edge k → in_sharing loaded at edge k.
  - Feedback loads at edges k + j·LAT for j = 1..ROUNDS.
  - out_valid is high in the cycle after edge k + ROUNDS·LAT.
  - Total of ROUNDS·LAT + 1 cycles from start to out_valid.
- start is ignored in RUN and DONE; no queuing.
- Back-to-back runs: start sampled in the IDLE cycle that immediately follows DONE is accepted.
- LAT = 1: a feedback load occurs on every RUN cycle.
- ROUNDS = 1: exactly one feedback load, then DONE.

Optional Feature:
- Macro: MSK_LOOP_CLEAR_EN.
- Defined:
  - On the DONE→IDLE edge, the state register is cleared to all zeros.
  - state_sharing reads zero from the first IDLE cycle after out_valid.
  - The result is valid only during the out_valid cycle.
- Undefined: the state register holds the final result through IDLE until the next start load.

Test Plan:
- Settings for all cases: d=2, count=1, ROUNDS=3, LAT=2.
- Assert rst mid-cycle during RUN round 1 → state_sharing = 2'b00, busy = 0, round = 0 immediately (before the next clk edge); no out_valid follows.
- start = 1 with in_sharing = 2'b10, round function modelled as 2-cycle bitwise NOT → state 10→01→10→01; out_valid high exactly 7 cycles after start is sampled; state_sharing = 2'b01 during out_valid.
- Pulse start again during RUN and during DONE → ignored; exactly one out_valid pulse; round sequence 0,0,1,1,2,2,3.
- Assert start in the IDLE cycle directly after DONE, in_sharing = 2'b11 → new run accepted; second out_valid 7 cycles later with state_sharing = 2'b00.
- mux_sel trace: 1 in IDLE, 0 for all 7 RUN/DONE cycles; the register never changes on non-load cycles even when fb_sharing toggles every cycle.
- Build with and without MSK_LOOP_CLEAR_EN:
  - Defined: the cycle after out_valid shows state_sharing = 2'b00.
  - Undefined: it still shows 2'b01 ten cycles later.
